// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer: buffers operand pairs and feeds them two-phase to a sequenced adder, returning sum/timeout
module add_operand_sequencer #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] p,
  output logic [1:0]        p_seq,
  input  logic              add_res_valid,
  input  logic [DATA_W-1:0] add_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_err,
  output logic              busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND_P1, SEND_P2, WAIT_RES, OUT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_a_d [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];
  logic [DATA_W-1:0] mem_b_d [DEPTH];
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic              err_q, err_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              full, empty, push, pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign push  = in_valid && !full;
  assign pop   = state_q == IDLE && !empty;
  always_comb begin
    state_d  = state_q;
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    err_d    = err_q;
    timer_d  = timer_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_a_d[wr_ptr_q] = in_a;
      mem_b_d[wr_ptr_q] = in_b;
    end
    case (state_q)
      IDLE: if (!empty) begin
        op_a_d  = mem_a_q[rd_ptr_q];
        op_b_d  = mem_b_q[rd_ptr_q];
        state_d = SEND_P1;
      end
      SEND_P1: state_d = SEND_P2;
      SEND_P2: begin
        timer_d = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: if (add_res_valid) begin
        res_d   = add_s;
        err_d   = 1'b0;
        state_d = OUT;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        res_d   = '0;
        err_d   = 1'b1;
        state_d = OUT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mem_a_q  <= '{default: '0};
      mem_b_q  <= '{default: '0};
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_a_q  <= mem_a_d;
      mem_b_q  <= mem_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  assign in_ready  = !full;
  assign p_seq     = state_q == SEND_P1 ? 2'd1 : state_q == SEND_P2 ? 2'd2 : 2'd0;
  assign p         = state_q == SEND_P1 ? op_a_q : state_q == SEND_P2 ? op_b_q : '0;
  assign out_valid = state_q == OUT;
  assign out_s     = res_q;
  assign out_err   = err_q;
  assign busy      = state_q != IDLE || !empty;
endmodule

// File: tb/tb_add_operand_sequencer.sv
// tb_add_operand_sequencer: table vectors plus scoreboard against a sequenced-adder stub
module tb_add_operand_sequencer;
  localparam int DW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err, busy;
  logic [DW-1:0] in_a = '0, in_b = '0, p, add_s, out_s;
  logic [1:0] p_seq;
  logic add_res_valid;
  logic no_resp = 1'b0, force_rv = 1'b0;
  logic [DW-1:0] stub_a, stub_s;
  logic stub_rv;
  int checks = 0, errors = 0;
  logic [DW:0] sb [$];
  typedef struct {logic [DW-1:0] a, b, s; logic err;} vec_t;
  vec_t vecs [6];

  add_operand_sequencer #(.DATA_W(DW), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .p(p), .p_seq(p_seq),
    .add_res_valid(add_res_valid), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // adder stub: latches first operand, registers the sum on the second, holds res_valid as a level
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_a <= '0; stub_s <= '0; stub_rv <= 1'b0;
    end else if (p_seq == 2'd1) begin
      stub_a <= p; stub_rv <= 1'b0;
    end else if (p_seq == 2'd2 && !no_resp) begin
      stub_s <= stub_a + p; stub_rv <= 1'b1;
    end
  end
  assign add_res_valid = stub_rv | force_rv;
  assign add_s = force_rv ? 4'hE : stub_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          logic [DW:0] e;
          e = sb.pop_front();
          chk("sb_s", out_s, e[DW-1:0]);
          chk("sb_err", out_err, e[DW]);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(no_resp ? {1'b1, {DW{1'b0}}} : {1'b0, DW'(in_a + in_b)});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < max);
    if (!out_valid) chk("wait_out_timeout", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd3, 4'd4, 4'd7, 1'b0};
    vecs[1] = '{4'd9, 4'd8, 4'd1, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 4'd14, 1'b0};
    vecs[3] = '{4'd0, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{4'd8, 4'd8, 4'd0, 1'b0};
    vecs[5] = '{4'd1, 4'd14, 4'd15, 1'b0};
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_p", p, 0);
    chk("rst_p_seq", p_seq, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // two-phase serialisation and 4-edge latency
    push_pair(4'd3, 4'd4);
    @(negedge clk); chk("t1_idle_pseq", p_seq, 0);
    @(negedge clk); chk("t1_p1_seq", p_seq, 1); chk("t1_p1", p, 3);
    @(negedge clk); chk("t1_p2_seq", p_seq, 2); chk("t1_p2", p, 4);
    @(negedge clk); chk("t1_wait_ov", out_valid, 0); chk("t1_wait_pseq", p_seq, 0);
    @(negedge clk); chk("t1_ov", out_valid, 1); chk("t1_s", out_s, 7); chk("t1_err", out_err, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      push_pair(vecs[i].a, vecs[i].b);
      wait_out(20);
      chk("vec_s", out_s, vecs[i].s);
      chk("vec_err", out_err, vecs[i].err);
      tick();
    end
    // back-pressure: fill FIFO while result is held
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = DW'(2 * i + 1); in_b = DW'(2 * i + 2);
      @(negedge clk); chk("t3_in_ready_fill", in_ready, 1);
      tick();
    end
    in_a = 4'd7; in_b = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full", in_ready, 0);
      chk("t3_hold_ov", out_valid, 1);
      chk("t3_hold_s", out_s, 3);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && (sb.size() > 0 || busy); n++) @(negedge clk);
    chk("t3_drained", sb.size(), 0);
    chk("t3_busy", busy, 0);
    tick();
    // adder never responds
    no_resp = 1'b1;
    push_pair(4'd2, 4'd2);
    repeat (11) @(negedge clk);
    chk("t4_ov_early", out_valid, 0);
    @(negedge clk);
    chk("t4_ov", out_valid, 1); chk("t4_err", out_err, 1); chk("t4_s", out_s, 0);
    tick();
    no_resp = 1'b0;
    push_pair(4'd4, 4'd5);
    wait_out(20);
    chk("t4_next_s", out_s, 9); chk("t4_next_err", out_err, 0);
    tick();
    // spurious res_valid outside WAIT_RES
    force_rv = 1'b1;
    tick(); tick();
    @(negedge clk); chk("t5_idle_ov", out_valid, 0); chk("t5_idle_busy", busy, 0);
    tick();
    push_pair(4'd2, 4'd3);
    for (int n = 0; n < 10 && p_seq != 2'd2; n++) @(negedge clk);
    chk("t5_saw_p2", p_seq, 2);
    force_rv = 1'b0;
    wait_out(20);
    chk("t5_s", out_s, 5); chk("t5_err", out_err, 0);
    tick();
    // reset during WAIT_RES with two pairs queued
    no_resp = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = DW'(i + 1); in_b = 4'd1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_p_seq", p_seq, 0); chk("t6_p", p, 0); chk("t6_ov", out_valid, 0);
    chk("t6_in_ready", in_ready, 1); chk("t6_busy", busy, 0);
    chk("t6_s", out_s, 0); chk("t6_err", out_err, 0);
    tick();
    rst_n = 1'b1;
    no_resp = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t6_post_busy", busy, 0);
      chk("t6_post_ov", out_valid, 0);
    end
    tick();
    push_pair(4'd6, 4'd7);
    wait_out(20);
    chk("t6_recover_s", out_s, 13);
    tick(); tick();
    chk("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
